t5_lsu: RTL and testbench
=========================

Name: t5_lsu

Overview:
- Memory-stage load/store unit. Consumes the execute-stage outputs (opcode, funct3, replicated store data) plus the effective address.
- Runs a single-outstanding data-bus transaction (stb/ack handshake) and returns aligned, sign/zero-extended load data.
- Drives `mstl` to freeze the pipeline until the access completes, times out, or is rejected as misaligned.

Parameters:
- `XLEN`, 32, data/address width.
- `TMO`, 16, BUSY cycles without ack before the access is aborted (valid range 2..255).

Ports:
- `sclk`  in  1  clock.
- `srst`  in  1  reset, synchronous, active-high.
- `xopc`  in  [6:2]  execute-stage opcode; `5'h00` = LOAD, `5'h08` = STORE, all other values = no access.
- `xfn3`  in  [14:12]  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `xea`  in  [31:0]  effective address.
- `xdat`  in  [31:0]  store data, already lane-replicated upstream.
- `dwb_adr_o`  out  [31:0]  word address; bits [1:0] always 0.
- `dwb_dat_o`  out  [31:0]  write data.
- `dwb_sel_o`  out  [3:0]  byte lane enables.
- `dwb_we_o`  out  1  write strobe qualifier.
- `dwb_stb_o`  out  1  request, registered.
- `dwb_dat_i`  in  [31:0]  read data.
- `dwb_ack_i`  in  1  transfer acknowledge.
- `mdat`  out  [31:0]  load result, valid in DONE.
- `mstl`  out  1  pipeline stall, combinational.
- `mmis`  out  1  misaligned/illegal-size fault, valid in DONE.
- `merr`  out  1  bus timeout fault, valid in DONE.

Behaviour:
- Clock/reset: one clock `sclk`; synchronous active-high `srst`.
- Reset values: state IDLE, `dwb_stb_o`=0, `dwb_we_o`=0, `dwb_sel_o`=0, `dwb_adr_o`=0, `dwb_dat_o`=0, `mdat`=0, `mmis`=0, `merr`=0, timeout counter=0.
- `req` = (`xopc`==`5'h00`) | (`xopc`==`5'h08`).
- `bad` = illegal size (`xfn3[13:12]`==11, or store with `xfn3[14]`=1, or load with `xfn3`==110) | (half & `xea[0]`) | (word & `xea[1:0]`!=0).
- IDLE:
  - `req` & !`bad` -> BUSY. At that edge, register `stb`=1, `we`=(store), `adr`={`xea[31:2]`,00}, `dat`=`xdat`, `sel`, and latch `xea[1:0]` and `xfn3`.
  - `req` & `bad` -> DONE with `mmis`=1; no bus cycle.
  - Otherwise stay in IDLE.
- Byte lane enables (`sel`): byte = 0001<<`xea[1:0]`; half = `xea[1]` ? 1100 : 0011; word = 1111.
- BUSY:
  - `stb` held high and all bus outputs stable until ack.
  - On `dwb_ack_i`: `stb`→0; load: `mdat` = selected lane, sign-extended unless `fn3[14]`=1; store: `mdat`=0; → DONE.
  - No ack: counter increments. When counter==`TMO`-1 without ack: `stb`→0, `merr`=1, `mdat`=0, → DONE.
  - Ack in the same cycle as timeout: ack wins, `merr`=0.
- DONE: lasts exactly one cycle, `mstl`=0, pipeline advances. Next state IDLE; `mmis`/`merr` cleared and counter reset on exit.
- `mstl` = (IDLE & `req`) | BUSY. `mstl` is low in DONE, which prevents re-issue of the held instruction.
- Lane extraction:
  - byte k = `dwb_dat_i[8k+7:8k]`.
  - half = `xea[1]` ? `dat_i[31:16]` : `dat_i[15:0]`.
- `dwb_ack_i` while IDLE or DONE: ignored, no state change.
- `srst` in any state: next edge IDLE, `stb`=0; a late ack after reset is ignored.
- Latency: aligned access with ack on the first `stb` cycle → `mstl` high 2 cycles, `mdat` valid in cycle 3.

Test Plan:
- LB at `xea`=0x1003, `dat_i`=0x80FF_1234, ack next cycle -> `sel`=1000, `adr`=0x1000, `mstl` high 2 cycles, `mdat`=0xFFFF_FF80 in DONE.
- LHU at `xea`=0x2002, `dat_i`=0x8001_0000 -> `sel`=1100, `mdat`=0x0000_8001. LH at the same address gives `mdat`=0xFFFF_8001.
- SW `xea`=0x40, `xdat`=0xDEAD_BEEF, ack delayed 3 cycles -> `we`=1, `sel`=1111, `dat_o` stable throughout, `mstl` high 4 cycles, then DONE with `mdat`=0.
- LW at `xea`=0x41 -> no `stb`, next cycle DONE with `mmis`=1. SH with `xfn3`=101 -> `mmis`=1, no bus cycle.
- LW with no ack, `TMO`=16 -> `stb` high 16 cycles, then DONE with `merr`=1, `mdat`=0. Repeat with ack on cycle 16 -> `merr`=0, data returned.
- `srst` in the 2nd BUSY cycle, then ack one cycle later -> `stb`=0 after the reset edge, state IDLE, ack ignored, `mdat`=0.

Source files
------------

// File: rtl/t5_lsu.sv
// t5_lsu: memory-stage load/store unit.
//
// This unit takes the execute-stage opcode, size field, effective address and
// replicated store data. It runs one data-bus transaction at a time using a
// stb/ack handshake, and only one transaction can be outstanding. It returns
// the loaded lane, aligned and sign- or zero-extended.
//
// While the access is in flight, mstl holds the pipeline. The access ends in
// one of three ways: it completes, it times out, or it is rejected as
// misaligned or of illegal size.
//
// Ports:
//   sclk, srst     clock; synchronous active-high reset
//   xopc[6:2]      opcode: 5'h00 LOAD, 5'h08 STORE, any other value = no access
//   xfn3[14:12]    size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   xea            effective address
//   xdat           store data, already replicated across the byte lanes
//   dwb_*          data bus master: adr/dat/sel/we/stb out, dat_i/ack_i in
//   mdat           load result, valid in DONE
//   mstl           pipeline stall (combinational)
//   mmis, merr     misaligned/illegal-size fault and bus-timeout fault,
//                  both valid in DONE
module t5_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TMO  = 16
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic [6:2]      xopc,
  input  logic [14:12]    xfn3,
  input  logic [XLEN-1:0] xea,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] dwb_adr_o,
  output logic [XLEN-1:0] dwb_dat_o,
  output logic [3:0]      dwb_sel_o,
  output logic            dwb_we_o,
  output logic            dwb_stb_o,
  input  logic [XLEN-1:0] dwb_dat_i,
  input  logic            dwb_ack_i,
  output logic [XLEN-1:0] mdat,
  output logic            mstl,
  output logic            mmis,
  output logic            merr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  ea_q;
  logic [2:0]  fn3_q;

  logic        is_ld, is_st, req, illegal, mis, bad, timeout;
  logic [1:0]  sz;
  logic [3:0]  sel_nxt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;
  logic [XLEN-1:0] ld_ext;

  // Request decode and fault classification
  always_comb begin
    is_ld   = (xopc == 5'h00);
    is_st   = (xopc == 5'h08);
    req     = is_ld | is_st;
    sz      = xfn3[13:12];
    illegal = (sz == 2'b11) | (is_st & xfn3[14]) | (is_ld & (xfn3 == 3'b110));
    mis     = ((sz == 2'b01) & xea[0]) | ((sz == 2'b10) & (xea[1:0] != 2'b00));
    bad     = illegal | mis;
    case (sz)
      2'b00:   sel_nxt = 4'b0001 << xea[1:0];
      2'b01:   sel_nxt = xea[1] ? 4'b1100 : 4'b0011;
      default: sel_nxt = 4'b1111;
    endcase
  end

  // Lane extraction. This uses the offset and size latched at issue, so the
  // result does not depend on what the stalled pipeline presents meanwhile.
  always_comb begin
    case (ea_q)
      2'd0:    byte_v = dwb_dat_i[7:0];
      2'd1:    byte_v = dwb_dat_i[15:8];
      2'd2:    byte_v = dwb_dat_i[23:16];
      default: byte_v = dwb_dat_i[31:24];
    endcase
    half_v = ea_q[1] ? dwb_dat_i[31:16] : dwb_dat_i[15:0];
    case (fn3_q[13:12])
      2'b00: begin
        sgn    = ~fn3_q[14] & byte_v[7];
        ld_ext = {{(XLEN-8){sgn}}, byte_v};
      end
      2'b01: begin
        sgn    = ~fn3_q[14] & half_v[15];
        ld_ext = {{(XLEN-16){sgn}}, half_v};
      end
      default: begin
        sgn    = 1'b0;
        ld_ext = dwb_dat_i;
      end
    endcase
  end

  assign timeout = (cnt == TMO_LAST);

  always_ff @(posedge sclk) begin
    if (srst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mstl      = 1'b0;
    case (state)
      S_IDLE: begin
        mstl = req;
        if (req) state_nxt = bad ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        mstl = 1'b1;
        if (dwb_ack_i || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus registers and results. An ack that arrives in the timeout cycle is
  // checked first, so the ack takes priority over the timeout.
  always_ff @(posedge sclk) begin
    if (srst) begin
      dwb_stb_o <= 1'b0;
      dwb_we_o  <= 1'b0;
      dwb_sel_o <= '0;
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      mdat      <= '0;
      mmis      <= 1'b0;
      merr      <= 1'b0;
      cnt       <= '0;
      ea_q      <= '0;
      fn3_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !bad) begin
            dwb_stb_o <= 1'b1;
            dwb_we_o  <= is_st;
            dwb_adr_o <= {xea[XLEN-1:2], 2'b00};
            dwb_dat_o <= xdat;
            dwb_sel_o <= sel_nxt;
            ea_q      <= xea[1:0];
            fn3_q     <= xfn3;
            cnt       <= '0;
          end else if (req) begin
            mmis <= 1'b1;
            mdat <= '0;
          end
        end
        S_BUSY: begin
          if (dwb_ack_i) begin
            dwb_stb_o <= 1'b0;
            mdat      <= dwb_we_o ? '0 : ld_ext;
          end else if (timeout) begin
            dwb_stb_o <= 1'b0;
            merr      <= 1'b1;
            mdat      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          mmis <= 1'b0;
          merr <= 1'b0;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t5_lsu.sv
module tb_t5_lsu;

  logic        sclk = 1'b0;
  logic        srst;
  logic [6:2]  xopc;
  logic [14:12] xfn3;
  logic [31:0] xea, xdat;
  logic [31:0] dwb_adr_o, dwb_dat_o, dwb_dat_i;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o, dwb_stb_o, dwb_ack_i;
  logic [31:0] mdat;
  logic        mstl, mmis, merr;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] OP_LD = 5'h00;
  localparam logic [4:0] OP_ST = 5'h08;
  localparam logic [4:0] OP_NO = 5'h04;

  t5_lsu #(.XLEN(32), .TMO(16)) dut (
    .sclk(sclk), .srst(srst),
    .xopc(xopc), .xfn3(xfn3), .xea(xea), .xdat(xdat),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o),
    .dwb_we_o(dwb_we_o), .dwb_stb_o(dwb_stb_o),
    .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
    .mdat(mdat), .mstl(mstl), .mmis(mmis), .merr(merr)
  );

  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Issue one aligned access. The ack is driven in BUSY cycle number ackat
  // (counting from 0); if ackat is ebusy or more, no ack is given. The task
  // expects exactly ebusy BUSY cycles, followed by a single DONE cycle.
  task automatic access(input string nm, input logic [4:0] opc, input logic [2:0] fn3,
                        input logic [31:0] ea, input logic [31:0] xd, input logic [31:0] rd,
                        input int ackat, input int ebusy, input logic [3:0] esel,
                        input logic ewe, input logic [31:0] emdat, input logic emerr);
    xopc = opc; xfn3 = fn3; xea = ea; xdat = xd; dwb_dat_i = rd; dwb_ack_i = 1'b0;
    #1;
    chk({nm, ".mstl_issue"}, 32'(mstl), 32'd1);
    for (int i = 0; i < ebusy; i++) begin
      tick();
      chk({nm, ".stb"},  32'(dwb_stb_o), 32'd1);
      chk({nm, ".adr"},  dwb_adr_o, {ea[31:2], 2'b00});
      chk({nm, ".sel"},  32'(dwb_sel_o), 32'(esel));
      chk({nm, ".we"},   32'(dwb_we_o), 32'(ewe));
      chk({nm, ".dato"}, dwb_dat_o, xd);
      chk({nm, ".mstl_busy"}, 32'(mstl), 32'd1);
      dwb_ack_i = (i == ackat);
    end
    tick();
    dwb_ack_i = 1'b0;
    #1;
    chk({nm, ".stb_done"},  32'(dwb_stb_o), 32'd0);
    chk({nm, ".mstl_done"}, 32'(mstl), 32'd0);
    chk({nm, ".mdat"},      mdat, emdat);
    chk({nm, ".merr"},      32'(merr), 32'(emerr));
    chk({nm, ".mmis"},      32'(mmis), 32'd0);
    xopc = OP_NO;
    tick();
    chk({nm, ".mstl_idle"}, 32'(mstl), 32'd0);
    chk({nm, ".merr_clr"},  32'(merr), 32'd0);
  endtask

  // An access that should be rejected: no bus cycle, and one DONE cycle with
  // mmis set.
  task automatic reject(input string nm, input logic [4:0] opc, input logic [2:0] fn3,
                        input logic [31:0] ea);
    xopc = opc; xfn3 = fn3; xea = ea; xdat = 32'h1111_2222;
    #1;
    chk({nm, ".mstl_issue"}, 32'(mstl), 32'd1);
    tick();
    chk({nm, ".stb"},  32'(dwb_stb_o), 32'd0);
    chk({nm, ".mmis"}, 32'(mmis), 32'd1);
    chk({nm, ".mstl_done"}, 32'(mstl), 32'd0);
    xopc = OP_NO;
    tick();
    chk({nm, ".mmis_clr"}, 32'(mmis), 32'd0);
    chk({nm, ".stb_idle"}, 32'(dwb_stb_o), 32'd0);
  endtask

  initial begin
    srst = 1'b1; xopc = OP_NO; xfn3 = 3'b000; xea = '0; xdat = '0;
    dwb_dat_i = '0; dwb_ack_i = 1'b0;
    tick(); tick();
    chk("rst.stb",  32'(dwb_stb_o), 32'd0);
    chk("rst.we",   32'(dwb_we_o), 32'd0);
    chk("rst.sel",  32'(dwb_sel_o), 32'd0);
    chk("rst.adr",  dwb_adr_o, 32'd0);
    chk("rst.dato", dwb_dat_o, 32'd0);
    chk("rst.mdat", mdat, 32'd0);
    chk("rst.mmis", 32'(mmis), 32'd0);
    chk("rst.merr", 32'(merr), 32'd0);
    chk("rst.mstl", 32'(mstl), 32'd0);
    srst = 1'b0;

    // An ack while IDLE must be ignored.
    dwb_ack_i = 1'b1;
    tick();
    dwb_ack_i = 1'b0;
    chk("idle_ack.stb",  32'(dwb_stb_o), 32'd0);
    chk("idle_ack.mdat", mdat, 32'd0);

    access("lb",  OP_LD, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1,
           4'b1000, 1'b0, 32'hFFFF_FF80, 1'b0);
    access("lbu", OP_LD, 3'b100, 32'h0000_1001, 32'h0, 32'h80FF_9234, 0, 1,
           4'b0010, 1'b0, 32'h0000_0092, 1'b0);
    access("lhu", OP_LD, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 1,
           4'b1100, 1'b0, 32'h0000_8001, 1'b0);
    access("lh",  OP_LD, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 1,
           4'b1100, 1'b0, 32'hFFFF_8001, 1'b0);
    access("lh0", OP_LD, 3'b001, 32'h0000_2000, 32'h0, 32'h8001_7FFE, 0, 1,
           4'b0011, 1'b0, 32'h0000_7FFE, 1'b0);
    access("sw",  OP_ST, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h5555_5555, 2, 3,
           4'b1111, 1'b1, 32'h0000_0000, 1'b0);
    access("sb",  OP_ST, 3'b000, 32'h0000_0082, 32'hABAB_ABAB, 32'h0, 0, 1,
           4'b0100, 1'b1, 32'h0000_0000, 1'b0);

    reject("lw_mis", OP_LD, 3'b010, 32'h0000_0041);
    reject("sh_bad", OP_ST, 3'b101, 32'h0000_0040);
    reject("lh_odd", OP_LD, 3'b001, 32'h0000_0043);
    reject("l110",   OP_LD, 3'b110, 32'h0000_0040);

    access("lw_tmo", OP_LD, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 99, 16,
           4'b1111, 1'b0, 32'h0000_0000, 1'b1);
    access("lw_ack16", OP_LD, 3'b010, 32'h0000_0304, 32'h0, 32'h1234_5678, 15, 16,
           4'b1111, 1'b0, 32'h1234_5678, 1'b0);

    // Reset in the 2nd BUSY cycle, then a late ack that must be ignored.
    xopc = OP_LD; xfn3 = 3'b010; xea = 32'h0000_0100; dwb_dat_i = 32'h7777_7777;
    tick();
    chk("srst.stb1", 32'(dwb_stb_o), 32'd1);
    tick();
    chk("srst.stb2", 32'(dwb_stb_o), 32'd1);
    srst = 1'b1;
    tick();
    chk("srst.stb_after", 32'(dwb_stb_o), 32'd0);
    chk("srst.mdat",      mdat, 32'd0);
    srst = 1'b0; xopc = OP_NO; dwb_ack_i = 1'b1;
    #1;
    chk("srst.mstl_idle", 32'(mstl), 32'd0);
    tick();
    dwb_ack_i = 1'b0;
    chk("srst.late_stb",  32'(dwb_stb_o), 32'd0);
    chk("srst.late_mdat", mdat, 32'd0);
    chk("srst.late_merr", 32'(merr), 32'd0);
    chk("srst.late_mstl", 32'(mstl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
